// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register with valid/ready flow
// control. It has a 2-entry skid buffer (main entry M plus spill entry S),
// a synchronous flush, and bubble gating of the control enables.
// in_ready comes straight from a flop, so there is no combinational path
// from out_ready to in_ready.
// Optional feature macro: PIPE_STAGE_STALL_CNT_EN adds a saturating stall
// counter output (stall_cnt). rst clears it; flush does not.
module pipe_stage_reg #(
    parameter int CTRL_W = 3,
    parameter int DATA_W = 64,
    parameter int DEST_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [DEST_W-1:0] out_dest,
`ifdef PIPE_STAGE_STALL_CNT_EN
    output logic [CNT_W-1:0]  stall_cnt,
`endif
    output logic [1:0]        occupancy
);

    // Main entry (drives the outputs) and skid entry (one spill slot).
    logic              m_valid_r, s_valid_r;
    logic [CTRL_W-1:0] m_ctrl_r,  s_ctrl_r;
    logic [DATA_W-1:0] m_data_r,  s_data_r;
    logic [DEST_W-1:0] m_dest_r,  s_dest_r;

    // Output-side registers, computed from next-state values.
    logic              in_ready_r;
    logic [CTRL_W-1:0] out_ctrl_r;
    logic [1:0]        occupancy_r;

    // Next-state values.
    logic              accept_s;
    logic              m_free_s;
    logic              m_valid_nxt_s, s_valid_nxt_s;
    logic [CTRL_W-1:0] m_ctrl_nxt_s,  s_ctrl_nxt_s;
    logic [DATA_W-1:0] m_data_nxt_s,  s_data_nxt_s;
    logic [DEST_W-1:0] m_dest_nxt_s,  s_dest_nxt_s;

    assign accept_s = in_valid & in_ready_r;
    // M can take a new entry this edge if it is empty or being consumed.
    assign m_free_s = ~m_valid_r | out_ready;

    // Next-state selection for both entries; flush wins over everything.
    always_comb begin
        m_valid_nxt_s = m_valid_r;
        m_ctrl_nxt_s  = m_ctrl_r;
        m_data_nxt_s  = m_data_r;
        m_dest_nxt_s  = m_dest_r;
        s_valid_nxt_s = s_valid_r;
        s_ctrl_nxt_s  = s_ctrl_r;
        s_data_nxt_s  = s_data_r;
        s_dest_nxt_s  = s_dest_r;
        if (flush) begin
            // Fields are left stale on purpose; only the valid bits matter.
            m_valid_nxt_s = 1'b0;
            s_valid_nxt_s = 1'b0;
        end else if (m_free_s) begin
            if (s_valid_r) begin
                // Drain the spill entry first to keep FIFO order. in_ready
                // is low here, so no accept can collide with this move.
                m_valid_nxt_s = 1'b1;
                m_ctrl_nxt_s  = s_ctrl_r;
                m_data_nxt_s  = s_data_r;
                m_dest_nxt_s  = s_dest_r;
                s_valid_nxt_s = 1'b0;
            end else if (accept_s) begin
                m_valid_nxt_s = 1'b1;
                m_ctrl_nxt_s  = in_ctrl;
                m_data_nxt_s  = in_data;
                m_dest_nxt_s  = in_dest;
            end else begin
                m_valid_nxt_s = 1'b0;
            end
        end else if (accept_s) begin
            // M is stalled: the incoming entry spills into S.
            s_valid_nxt_s = 1'b1;
            s_ctrl_nxt_s  = in_ctrl;
            s_data_nxt_s  = in_data;
            s_dest_nxt_s  = in_dest;
        end else begin
            s_valid_nxt_s = s_valid_r;
        end
    end

    // Entry storage and registered outputs, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_r   <= 1'b0;
            m_ctrl_r    <= {CTRL_W{1'b0}};
            m_data_r    <= {DATA_W{1'b0}};
            m_dest_r    <= {DEST_W{1'b0}};
            s_valid_r   <= 1'b0;
            s_ctrl_r    <= {CTRL_W{1'b0}};
            s_data_r    <= {DATA_W{1'b0}};
            s_dest_r    <= {DEST_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_ctrl_r  <= {CTRL_W{1'b0}};
            occupancy_r <= 2'd0;
        end else begin
            m_valid_r   <= m_valid_nxt_s;
            m_ctrl_r    <= m_ctrl_nxt_s;
            m_data_r    <= m_data_nxt_s;
            m_dest_r    <= m_dest_nxt_s;
            s_valid_r   <= s_valid_nxt_s;
            s_ctrl_r    <= s_ctrl_nxt_s;
            s_data_r    <= s_data_nxt_s;
            s_dest_r    <= s_dest_nxt_s;
            in_ready_r  <= ~s_valid_nxt_s;
            // A bubble never shows enables, even though stale fields remain.
            out_ctrl_r  <= m_valid_nxt_s ? m_ctrl_nxt_s : {CTRL_W{1'b0}};
            occupancy_r <= {1'b0, m_valid_nxt_s} + {1'b0, s_valid_nxt_s};
        end
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_r;

    // Count edges where the main entry is valid but blocked; saturate; flush does not clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (m_valid_r && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = m_valid_r;
    assign out_ctrl  = out_ctrl_r;
    assign out_data  = m_data_r;
    assign out_dest  = m_dest_r;
    assign occupancy = occupancy_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg. Directed stimulus pushes the expected
// entries into a queue. An independent negedge monitor pops one entry and
// compares it on every output handshake.
module tb_pipe_stage_reg;

    localparam int CTRL_W = 3;
    localparam int DATA_W = 64;
    localparam int DEST_W = 5;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        logic [DEST_W-1:0] dest;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic [DEST_W-1:0] in_dest = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [DEST_W-1:0] out_dest;
    logic [1:0]        occupancy;
`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    entry_t sb_q[$];

    pipe_stage_reg #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .DEST_W(DEST_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_dest(in_dest),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .out_dest(out_dest),
`ifdef PIPE_STAGE_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one entry onto the input (does not advance the clock).
    task automatic offer(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                         input logic [DEST_W-1:0] t);
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
        in_dest  = t;
    endtask

    task automatic expect_entry(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                                input logic [DEST_W-1:0] t);
        entry_t e;
        e.ctrl = c;
        e.data = d;
        e.dest = t;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got dest %0d with empty scoreboard", out_dest);
            end else begin
                entry_t e;
                e = sb_q.pop_front();
                check("out_dest", 64'(out_dest), 64'(e.dest));
                check("out_data", out_data, e.data);
                check("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
            end
        end
    end

    initial begin
        // Reset
        rst = 1'b1;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        rst = 1'b0;
        step();

        // 1. Pass-through
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(3'b101, 64'h1 + 64'(i), 5'(7 + i));
            check("pt_in_ready", 64'(in_ready), 64'd1);
            expect_entry(3'b101, 64'h1 + 64'(i), 5'(7 + i));
            step();
            check("pt_occupancy", 64'(occupancy), 64'd1);
            check("pt_latency_dest", 64'(out_dest), 64'(7 + i));
        end
        in_valid = 1'b0;
        step();
        check("pt_drain_occ", 64'(occupancy), 64'd0);

        // 2. Backpressure
        out_ready = 1'b0;
        offer(3'b001, 64'hA, 5'd3);
        expect_entry(3'b001, 64'hA, 5'd3);
        step();
        check("bp_occ_a", 64'(occupancy), 64'd1);
        offer(3'b010, 64'hB, 5'd4);
        check("bp_ready_b", 64'(in_ready), 64'd1);
        expect_entry(3'b010, 64'hB, 5'd4);
        step();
        check("bp_ready_full", 64'(in_ready), 64'd0);
        check("bp_occ_full", 64'(occupancy), 64'd2);
        offer(3'b011, 64'hC, 5'd5);
        step();
        check("bp_c_rejected_occ", 64'(occupancy), 64'd2);
        check("bp_head_dest", 64'(out_dest), 64'd3);
        out_ready = 1'b1;
        step();
        check("bp_ready_again", 64'(in_ready), 64'd1);
        check("bp_occ_after_pop", 64'(occupancy), 64'd1);
        expect_entry(3'b011, 64'hC, 5'd5);
        step();
        in_valid = 1'b0;
        step();
        check("bp_drained", 64'(occupancy), 64'd0);

        // 3. Flush at full occupancy
        out_ready = 1'b0;
        offer(3'b110, 64'hD, 5'd10);
        expect_entry(3'b110, 64'hD, 5'd10);
        step();
        offer(3'b110, 64'hE, 5'd11);
        expect_entry(3'b110, 64'hE, 5'd11);
        step();
        check("fl_occ_full", 64'(occupancy), 64'd2);
        flush = 1'b1;
        offer(3'b111, 64'hF, 5'd12);
        sb_q.delete();
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_out_ctrl", 64'(out_ctrl), 64'd0);
        check("fl_occupancy", 64'(occupancy), 64'd0);
        check("fl_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        step();
        step();
        check("fl_no_ghost", 64'(out_valid), 64'd0);

        // 4. Bubble gating
        offer(3'b111, 64'h55, 5'd20);
        expect_entry(3'b111, 64'h55, 5'd20);
        step();
        in_valid = 1'b0;
        check("bg_ctrl_live", 64'(out_ctrl), 64'd7);
        step();
        check("bg_out_valid", 64'(out_valid), 64'd0);
        check("bg_ctrl_gated", 64'(out_ctrl), 64'd0);

        // 5. Async reset mid-transfer
        out_ready = 1'b0;
        offer(3'b101, 64'h66, 5'd21);
        expect_entry(3'b101, 64'h66, 5'd21);
        step();
        offer(3'b101, 64'h77, 5'd22);
        expect_entry(3'b101, 64'h77, 5'd22);
        step();
        in_valid = 1'b0;
        check("ar_occ_full", 64'(occupancy), 64'd2);
        #1 rst = 1'b1;
        #1;
        sb_q.delete();
        check("ar_out_valid", 64'(out_valid), 64'd0);
        check("ar_occupancy", 64'(occupancy), 64'd0);
        check("ar_out_ctrl", 64'(out_ctrl), 64'd0);
        check("ar_in_ready", 64'(in_ready), 64'd1);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        step();
        offer(3'b100, 64'h88, 5'd30);
        expect_entry(3'b100, 64'h88, 5'd30);
        step();
        in_valid = 1'b0;
        check("ar_first_after", 64'(out_dest), 64'd30);
        step();

`ifdef PIPE_STAGE_STALL_CNT_EN
        // 6. Stall counter saturation, flush immunity, rst clear
        rst = 1'b1;
        #1;
        rst = 1'b0;
        check("sc_reset", 64'(stall_cnt), 64'd0);
        out_ready = 1'b0;
        offer(3'b001, 64'h99, 5'd1);
        expect_entry(3'b001, 64'h99, 5'd1);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("sc_saturated", 64'(stall_cnt), 64'hF);
        flush = 1'b1;
        sb_q.delete();
        step();
        flush = 1'b0;
        check("sc_after_flush", 64'(stall_cnt), 64'hF);
        #1 rst = 1'b1;
        #1;
        check("sc_rst_clear", 64'(stall_cnt), 64'd0);
        rst = 1'b0;
        step();
`endif

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
